ascon_prog_sequencer: RTL and testbench

//  Program-driven command sequencer upstream of ASCON_System_no_io_compression.

---
 rtl/ascon_prog_sequencer_pkg.sv | 29 ++
 rtl/ascon_prog_ram.sv | 36 +++
 rtl/ascon_prog_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_ascon_prog_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_prog_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_prog_sequencer_pkg
//  Purpose  : Shared ASCON core opcode header used by the program sequencer
//             and anything that assembles programs for it.
//  Revision : 1.0  initial release
// ============================================================================
package ascon_prog_sequencer_pkg;

  localparam int OP_W = 6;

  // Core instruction opcodes
  localparam logic [OP_W-1:0] ASCON_KEY_LD             = 6'h01;
  localparam logic [OP_W-1:0] ASCON_NONCE_LD           = 6'h02;
  localparam logic [OP_W-1:0] ASCON_INIT               = 6'h03;
  localparam logic [OP_W-1:0] ASCON_DATA_FIFO_PUSH     = 6'h04;
  localparam logic [OP_W-1:0] ASCON_TXT_FIFO_PUSH      = 6'h05;
  localparam logic [OP_W-1:0] ASCON_PROCESS            = 6'h06;
  localparam logic [OP_W-1:0] ASCON_TEXT_OUT_FIFO_PULL = 6'h07;
  localparam logic [OP_W-1:0] ASCON_FINAL              = 6'h08;
  localparam logic [OP_W-1:0] ASCON_END                = 6'h3f;  // also the idle NOP

  // Opcodes that consume one block from the input stream before issue
  function automatic logic is_blk_op(input logic [OP_W-1:0] op);
    return (op == ASCON_DATA_FIFO_PUSH) || (op == ASCON_TXT_FIFO_PUSH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_prog_ram.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_prog_ram
//  Purpose  : Opcode program store, one write port and one synchronous read
//             port. Contents are not reset so a program survives a core reset.
//  Revision : 1.0  initial release
// ============================================================================
module ascon_prog_ram
  import ascon_prog_sequencer_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [OP_W-1:0]   wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [OP_W-1:0]   rdata
);

  logic [OP_W-1:0] mem [DEPTH];

  // Write port and registered read port; read data holds when re is low
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ascon_prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_prog_sequencer
//  Purpose  : Runs an opcode program against the ASCON core: issues each
//             opcode, feeds AD/text blocks from the input stream, paces on the
//             core ready flag and streams captured outputs.
//  Options  : ASCON_SEQ_TIMEOUT_EN - BUSY watchdog of TIMEOUT_CYC cycles,
//             expiry sets err and ends the run.
//  Revision : 1.0  initial release
// ============================================================================
module ascon_prog_sequencer
  import ascon_prog_sequencer_pkg::*;
#(
  parameter int WIDTH       = 128,
  parameter int PROG_DEPTH  = 32,
  parameter int PC_W        = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             prog_we,
  input  logic [PC_W-1:0]  prog_waddr,
  input  logic [5:0]       prog_wdata,
  input  logic             start,
  input  logic             mode_fast,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [5:0]       instruction,
  output logic             data_blk_en,
  output logic             txt_blk_en,
  output logic [WIDTH-1:0] data_block,
  output logic [WIDTH-1:0] txt_block,
  output logic             compact_fast,
  input  logic             status_rdy,
  input  logic [WIDTH-1:0] ascon_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] S_BOOT     = 4'd0;
  localparam logic [3:0] S_IDLE     = 4'd1;
  localparam logic [3:0] S_FETCH    = 4'd2;
  localparam logic [3:0] S_DECODE   = 4'd3;
  localparam logic [3:0] S_BLK_WAIT = 4'd4;
  localparam logic [3:0] S_ISSUE    = 4'd5;
  localparam logic [3:0] S_GUARD    = 4'd6;
  localparam logic [3:0] S_BUSY     = 4'd7;
  localparam logic [3:0] S_EMIT     = 4'd8;
  localparam logic [3:0] S_ADV      = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

  logic [3:0]      state;
  logic [PC_W-1:0] pc;
  logic [5:0]      op;
  logic [5:0]      rd_op;
  logic            ram_we;
  logic            ram_re;

  // Program edits are only safe while no run is reading the RAM
  assign ram_we = prog_we && ((state == S_IDLE) || (state == S_DONE));
  assign ram_re = (state == S_FETCH);

  ascon_prog_ram #(
    .DEPTH  (PROG_DEPTH),
    .ADDR_W (PC_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_waddr),
    .wdata (prog_wdata),
    .re    (ram_re),
    .raddr (pc),
    .rdata (rd_op)
  );

  assign in_ready = (state == S_BLK_WAIT) && in_valid;
  assign done     = (state == S_DONE);
  assign busy     = !((state == S_BOOT) || (state == S_IDLE) || (state == S_DONE));

`ifdef ASCON_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_LAST);

  // Watchdog: cleared as BUSY is entered, counts every BUSY cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if (state == S_GUARD) begin
      to_cnt <= '0;
    end else if (state == S_BUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic to_hit;
  logic unused_timeout_cfg;

  assign to_hit             = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // Main sequencer: registered outputs are updated on the transition into
  // the state that presents them, so opcode and block enable line up in ISSUE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_BOOT;
      pc           <= '0;
      op           <= ASCON_END;
      instruction  <= ASCON_END;
      data_blk_en  <= 1'b0;
      txt_blk_en   <= 1'b0;
      data_block   <= '0;
      txt_block    <= '0;
      compact_fast <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      err          <= 1'b0;
    end else begin
      data_blk_en <= 1'b0;
      txt_blk_en  <= 1'b0;
      case (state)
        S_BOOT: begin
          if (status_rdy) begin
            state <= S_IDLE;
          end
        end
        S_IDLE, S_DONE: begin
          if (start) begin
            pc           <= '0;
            compact_fast <= mode_fast;
            err          <= 1'b0;
            state        <= S_FETCH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          op <= rd_op;
          if (rd_op == ASCON_END) begin
            instruction <= ASCON_END;
            state       <= S_DONE;
          end else if (is_blk_op(rd_op)) begin
            state <= S_BLK_WAIT;
          end else begin
            instruction <= rd_op;
            state       <= S_ISSUE;
          end
        end
        S_BLK_WAIT: begin
          if (in_valid) begin
            if (op == ASCON_DATA_FIFO_PUSH) begin
              data_block  <= in_data;
              data_blk_en <= 1'b1;
            end else begin
              txt_block  <= in_data;
              txt_blk_en <= 1'b1;
            end
            instruction <= op;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_GUARD;
        end
        // The core may still show ready from the previous step here
        S_GUARD: begin
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (status_rdy) begin
            if (op == ASCON_TEXT_OUT_FIFO_PULL) begin
              out_data  <= ascon_out;
              out_valid <= 1'b1;
              state     <= S_EMIT;
            end else begin
              state <= S_ADV;
            end
          end else if (to_hit) begin
            err         <= 1'b1;
            instruction <= ASCON_END;
            state       <= S_DONE;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_ADV;
          end
        end
        S_ADV: begin
          if (pc == PC_LAST) begin
            instruction <= ASCON_END;
            state       <= S_DONE;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ascon_prog_sequencer
//  Purpose  : Scoreboard bench for ascon_prog_sequencer. Stimulus pushes the
//             expected block loads, outputs and completions (with the cycle
//             they must appear on); a negedge monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ascon_prog_sequencer;
  import ascon_prog_sequencer_pkg::*;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rstn;
  logic         prog_we;
  logic [4:0]   prog_waddr;
  logic [5:0]   prog_wdata;
  logic         start;
  logic         mode_fast;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [5:0]   instruction;
  logic         data_blk_en;
  logic         txt_blk_en;
  logic [W-1:0] data_block;
  logic [W-1:0] txt_block;
  logic         compact_fast;
  logic         status_rdy;
  logic [W-1:0] ascon_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;
  logic         err;

  ascon_prog_sequencer #(
    .WIDTH       (W),
    .PROG_DEPTH  (32),
    .PC_W        (5),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .prog_we      (prog_we),
    .prog_waddr   (prog_waddr),
    .prog_wdata   (prog_wdata),
    .start        (start),
    .mode_fast    (mode_fast),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .instruction  (instruction),
    .data_blk_en  (data_blk_en),
    .txt_blk_en   (txt_blk_en),
    .data_block   (data_block),
    .txt_block    (txt_block),
    .compact_fast (compact_fast),
    .status_rdy   (status_rdy),
    .ascon_out    (ascon_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       txt;
    logic [W-1:0] data;
    logic [5:0] instr;
  } blk_t;

  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  blk_t         blk_q[$];
  logic [W-1:0] out_q[$];
  done_t        done_q[$];
  logic [W-1:0] in_q[$];
  logic [5:0]   prog[$];

  int total = 0;
  int bad   = 0;

  localparam logic [W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [W-1:0] PAT_5A = {16{8'h5A}};
  localparam logic [W-1:0] OUT_C1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [W-1:0] OUT_C2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT presentation is matched against the scoreboard
  blk_t  mb;
  done_t md;
  always @(negedge clk) begin
    if (rstn) begin
      if (data_blk_en || txt_blk_en) begin
        if (blk_q.size() == 0) begin
          total++; bad++;
          $display("FAIL blk_unexpected: got data_en=%0b txt_en=%0b at cyc %0d expected none", data_blk_en, txt_blk_en, cyc);
        end else begin
          mb = blk_q.pop_front();
          check("blk_cycle", W'(cyc), W'(mb.cyc));
          check("blk_kind", {txt_blk_en, data_blk_en}, mb.txt ? W'(2) : W'(1));
          check("blk_data", mb.txt ? txt_block : data_block, mb.data);
          check("blk_instr", W'(instruction), W'(mb.instr));
        end
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_unexpected: got %0h at cyc %0d expected none", out_data, cyc);
        end else begin
          check("out_data", out_data, out_q.pop_front());
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done at cyc %0d expected none", cyc);
        end else begin
          md = done_q.pop_front();
          check("done_cycle", W'(cyc), W'(md.cyc));
          check("done_err", W'(err), W'(md.err));
          check("done_instr", W'(instruction), W'(ASCON_END));
        end
      end
    end
  end

  // Input stream driver: presents queued blocks, retires them on handshake
  logic hs;
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) void'(in_q.pop_front());
      if (in_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = in_q[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      prog_we    = 1'b1;
      prog_waddr = 5'(i);
      prog_wdata = prog[i];
      step(1);
    end
    prog_we = 1'b0;
  endtask

  task automatic do_start(input logic fast, output int t0);
    start     = 1'b1;
    mode_fast = fast;
    t0        = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((done_q.size() != 0 || blk_q.size() != 0 || out_q.size() != 0) && n < limit) begin
      step(1);
      n++;
    end
    total++;
    if (n >= limit) begin
      bad++;
      $display("FAIL %s_timeout: got pending done=%0d blk=%0d out=%0d expected 0",
               name, done_q.size(), blk_q.size(), out_q.size());
      done_q.delete(); blk_q.delete(); out_q.delete();
    end
    step(2);
  endtask

  int t0;
  int hold_c;
  int n;

  initial begin
    rstn = 1'b0; prog_we = 1'b0; prog_waddr = '0; prog_wdata = '0;
    start = 1'b0; mode_fast = 1'b0; status_rdy = 1'b0;
    ascon_out = '0; out_ready = 1'b0;
    step(2);
    rstn = 1'b1;

    // 1: reset values, start during BOOT dropped, core ready after 3 cycles
    @(negedge clk);
    check("rst_instr", W'(instruction), W'(ASCON_END));
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_flags", W'({in_ready, out_valid, err, compact_fast, data_blk_en, txt_blk_en}), '0);
    check("rst_blocks", data_block | txt_block, '0);
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    status_rdy = 1'b1;
    @(negedge clk);
    check("boot_start_ignored", W'(busy), '0);
    step(3);
    @(negedge clk);
    check("idle_busy", W'(busy), '0);

    // 2: AD block load then KEY_LD then END
    step(1);
    prog = '{ASCON_DATA_FIFO_PUSH, ASCON_KEY_LD, ASCON_END};
    load_prog();
    in_q.push_back(PAT_A5);
    step(3);
    do_start(1'b0, t0);
    blk_q.push_back('{t0 + 4, 1'b0, PAT_A5, ASCON_DATA_FIFO_PUSH});
    done_q.push_back('{t0 + 16, 1'b0});
    drain("t2", 60);
    check("t2_mode", W'(compact_fast), '0);

    // 3: ready held high through GUARD; opcode rewritten on the start cycle
    prog = '{ASCON_TXT_FIFO_PUSH, ASCON_NONCE_LD, ASCON_END};
    load_prog();
    prog_we = 1'b1; prog_waddr = 5'd0; prog_wdata = ASCON_KEY_LD;
    do_start(1'b1, t0);
    prog_we = 1'b0;
    done_q.push_back('{t0 + 15, 1'b0});
    @(negedge clk);
    check("t3_mode_fast", W'(compact_fast), W'(1));
    check("t3_busy", W'(busy), W'(1));
    drain("t3", 60);

    // 4: text block then output pull held by out_ready low
    prog = '{ASCON_TXT_FIFO_PUSH, ASCON_TEXT_OUT_FIFO_PULL, ASCON_END};
    load_prog();
    in_q.push_back(PAT_5A);
    ascon_out = OUT_C1;
    step(3);
    do_start(1'b0, t0);
    blk_q.push_back('{t0 + 4, 1'b1, PAT_5A, ASCON_TXT_FIFO_PUSH});
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_valid_cycle", W'(cyc), W'(t0 + 13));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) ascon_out = OUT_C2;
      @(negedge clk);
      check("t4_hold_valid", W'(out_valid), W'(1));
      check("t4_hold_data", out_data, OUT_C1);
    end
    @(posedge clk);
    #1;
    hold_c = cyc;
    out_q.push_back(OUT_C1);
    done_q.push_back('{hold_c + 4, 1'b0});
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    @(negedge clk);
    check("t4_valid_drop", W'(out_valid), '0);
    drain("t4", 40);

    // 5: 32 non-END opcodes end implicitly after the last entry
    prog.delete();
    for (int i = 0; i < 32; i++) prog.push_back(ASCON_KEY_LD);
    load_prog();
    do_start(1'b0, t0);
    done_q.push_back('{t0 + 193, 1'b0});
    drain("t5", 260);
    check("t5_idle", W'(busy), '0);

    // 6: core ready stuck low in BUSY
    prog = '{ASCON_KEY_LD, ASCON_END};
    load_prog();
    status_rdy = 1'b0;
    do_start(1'b0, t0);
`ifdef ASCON_SEQ_TIMEOUT_EN
    done_q.push_back('{t0 + 13, 1'b1});
    drain("t6", 40);
    @(negedge clk);
    check("t6_err_sticky", W'(err), W'(1));
    status_rdy = 1'b1;
    step(1);
    do_start(1'b0, t0);
    done_q.push_back('{t0 + 9, 1'b0});
    @(negedge clk);
    check("t6_err_clear", W'(err), '0);
    drain("t6b", 40);
`else
    step(30);
    @(negedge clk);
    check("t6_still_busy", W'(busy), W'(1));
    check("t6_no_err", W'(err), '0);
    @(posedge clk);
    #1;
    status_rdy = 1'b1;
    done_q.push_back('{cyc + 4, 1'b0});
    drain("t6", 40);
`endif

    // 7: async reset mid-run, program RAM survives
    status_rdy = 1'b0;
    do_start(1'b0, t0);
    step(6);
    rstn = 1'b0;
    #1;
    check("t7_async_busy", W'(busy), '0);
    check("t7_async_instr", W'(instruction), W'(ASCON_END));
    step(2);
    rstn = 1'b1;
    status_rdy = 1'b1;
    step(3);
    do_start(1'b0, t0);
    done_q.push_back('{t0 + 9, 1'b0});
    drain("t7", 40);

    check("end_in_q", W'(in_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
